branch_predictor: RTL and testbench

Fetch-stage dynamic branch predictor: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Each cycle it looks up the fetch PC and drives the predicted direction and target to the PC-next select stage directly downstream.
- It is trained from the Execute stage with resolved outcomes, and raises the misprediction flag that the PC-next select uses to redirect fetch.

---
 rtl/branch_predictor_if.sv | 31 +++
 rtl/branch_predictor.sv | 77 +++++++
 tb/tb_branch_predictor.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/Execute bus between the pipeline and the branch predictor.
//   Fetch side  : PCF_i in, PredictTakenF_o / PredictTargetF_o back.
//   Execute side: resolved branch/jump information in, MispredictE_o back.
// master = pipeline (drives PCs and outcomes), slave = predictor.
interface branch_predictor_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] PCF_i;
   logic                  PredictTakenF_o;
   logic [DATA_WIDTH-1:0] PredictTargetF_o;
   logic                  BranchE_i;
   logic                  JumpE_i;
   logic [DATA_WIDTH-1:0] PCE_i;
   logic                  PCSrcE_i;
   logic [DATA_WIDTH-1:0] ActualTargetE_i;
   logic                  PredictTakenE_i;
   logic [DATA_WIDTH-1:0] PredictTargetE_i;
   logic                  MispredictE_o;

   modport master (
      output PCF_i, BranchE_i, JumpE_i, PCE_i, PCSrcE_i, ActualTargetE_i,
             PredictTakenE_i, PredictTargetE_i,
      input  PredictTakenF_o, PredictTargetF_o, MispredictE_o
   );

   modport slave (
      input  PCF_i, BranchE_i, JumpE_i, PCE_i, PCSrcE_i, ActualTargetE_i,
             PredictTakenE_i, PredictTargetE_i,
      output PredictTakenF_o, PredictTargetF_o, MispredictE_o
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating counter per entry.
//   clk_i : clock, all state changes on the rising edge
//   rst_i : synchronous active-high reset
//   bp    : predictor bus (slave side); fetch lookup is combinational from
//           registered state, Execute training writes on the clock edge.
module branch_predictor #(
   parameter int DATA_WIDTH  = 32,
   parameter int BTB_ENTRIES = 16,
   localparam int IDX_W      = $clog2(BTB_ENTRIES)
) (
   input logic               clk_i,
   input logic               rst_i,
   branch_predictor_if.slave bp
);
   localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

   logic [BTB_ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
   logic [DATA_WIDTH-1:0]  target_q [BTB_ENTRIES];
   logic [1:0]             ctr_q    [BTB_ENTRIES];

   logic [IDX_W-1:0] idx_f, idx_e;
   logic [TAG_W-1:0] tag_f, tag_e;
   logic             hit_f, hit_e, upd, taken, wr_en;
   logic [1:0]       ctr_n;

   // Low PC bits never take part in indexing or tag compare.
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{bp.PCF_i[1:0], bp.PCE_i[1:0]};

   // ---------------- fetch lookup ----------------
   assign idx_f = bp.PCF_i[IDX_W+1:2];
   assign tag_f = bp.PCF_i[DATA_WIDTH-1:IDX_W+2];
   assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

   // No bypass from a same-cycle update: lookup always sees stored state.
   assign bp.PredictTakenF_o  = !rst_i && hit_f && ctr_q[idx_f][1];
   assign bp.PredictTargetF_o = hit_f ? target_q[idx_f] : '0;

   // ---------------- execute training ----------------
   assign idx_e = bp.PCE_i[IDX_W+1:2];
   assign tag_e = bp.PCE_i[DATA_WIDTH-1:IDX_W+2];
   assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
   assign upd   = bp.BranchE_i || bp.JumpE_i;
   assign taken = bp.PCSrcE_i || bp.JumpE_i;

   assign bp.MispredictE_o = !rst_i && upd &&
      ((bp.PredictTakenE_i != taken) ||
       (taken && bp.PredictTakenE_i && (bp.PredictTargetE_i != bp.ActualTargetE_i)));

   // A not-taken miss never allocates, so an aliasing entry survives it.
   assign wr_en = upd && (hit_e || taken);

   always_comb begin
      ctr_n = ctr_q[idx_e];
      if (hit_e) begin
         if (bp.JumpE_i)                  ctr_n = 2'b11;
         else if (taken && ctr_n != 2'b11) ctr_n = ctr_n + 2'b01;
         else if (!taken && ctr_n != 2'b00) ctr_n = ctr_n - 2'b01;
      end else begin
         // Fresh allocation: jumps start strong-T, branches weak-T.
         ctr_n = bp.JumpE_i ? 2'b11 : 2'b10;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         for (int i = 0; i < BTB_ENTRIES; i++) ctr_q[i] <= 2'b01;
      end else if (wr_en) begin
         valid_q[idx_e] <= 1'b1;
         tag_q[idx_e]   <= tag_e;
         ctr_q[idx_e]   <= ctr_n;
         if (taken) target_q[idx_e] <= bp.ActualTargetE_i;
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: the driver pushes the reference model's expectation for
// every cycle; a monitor pops one entry per cycle at the falling edge.
module tb_branch_predictor;
   localparam int DW = 32;
   localparam int NE = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   branch_predictor_if #(.DATA_WIDTH(DW)) bus();

   branch_predictor #(.DATA_WIDTH(DW), .BTB_ENTRIES(NE)) dut (
      .clk_i(clk), .rst_i(rst), .bp(bus.slave)
   );

   typedef struct {
      logic          tk;
      logic [DW-1:0] tg;
      logic          mp;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: one record per slot, tag kept as the PC's upper bits,
   // strength held as an integer 0..3.
   bit        m_valid [NE];
   int        m_ctr   [NE];
   bit [31:0] m_tag   [NE];
   bit [31:0] m_tgt   [NE];

   function automatic int slot(input bit [31:0] pc);
      return int'((pc / 4) % NE);
   endfunction

   function automatic bit m_hit(input bit [31:0] pc);
      return m_valid[slot(pc)] && m_tag[slot(pc)] == (pc / (4 * NE));
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < NE; i++) begin
         m_valid[i] = 0;
         m_ctr[i]   = 1;
      end
   endfunction

   task automatic step(input bit r, input bit [31:0] pcf, input bit br, input bit jp,
                       input bit [31:0] pce, input bit src, input bit [31:0] act,
                       input bit pte, input bit [31:0] ptg);
      exp_t e;
      bit   upd, tk;
      int   s;
      @(posedge clk);
      #1;
      rst                  = r;
      bus.PCF_i            = pcf;
      bus.BranchE_i        = br;
      bus.JumpE_i          = jp;
      bus.PCE_i            = pce;
      bus.PCSrcE_i         = src;
      bus.ActualTargetE_i  = act;
      bus.PredictTakenE_i  = pte;
      bus.PredictTargetE_i = ptg;
      upd  = br || jp;
      tk   = src || jp;
      e.tk = !r && m_hit(pcf) && m_ctr[slot(pcf)] >= 2;
      e.tg = m_hit(pcf) ? m_tgt[slot(pcf)] : 32'h0;
      e.mp = !r && upd && (pte != tk || (tk && pte && ptg != act));
      sb.push_back(e);
      // state after the coming edge
      if (r) m_reset();
      else if (upd) begin
         s = slot(pce);
         if (m_hit(pce)) begin
            if (jp)      m_ctr[s] = 3;
            else if (tk) m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
            else         m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
            if (tk) m_tgt[s] = act;
         end else if (tk) begin
            m_valid[s] = 1;
            m_tag[s]   = pce / (4 * NE);
            m_tgt[s]   = act;
            m_ctr[s]   = jp ? 3 : 2;
         end
      end
   endtask

   task automatic look(input bit [31:0] pcf);
      step(0, pcf, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Monitor: the predictor answers every cycle, so one entry per cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("predict_taken",  {31'b0, bus.PredictTakenF_o}, {31'b0, e.tk});
            chk("predict_target", bus.PredictTargetF_o, e.tg);
            chk("mispredict",     {31'b0, bus.MispredictE_o}, {31'b0, e.mp});
         end
      end
   end

   function automatic bit [31:0] rnd_pc();
      return ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
   endfunction

   initial begin
      bit [31:0] pcf, pce, act, ptg;
      bit        br, jp, src, pte, r;
      bus.PCF_i = 0; bus.BranchE_i = 0; bus.JumpE_i = 0; bus.PCE_i = 0;
      bus.PCSrcE_i = 0; bus.ActualTargetE_i = 0; bus.PredictTakenE_i = 0;
      bus.PredictTargetE_i = 0;
      m_reset();
      @(posedge clk);                       // DUT state now defined
      step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
      look(32'h100);                        // cold miss
      // first allocation with fetch at the same index: visible next cycle
      step(0, 32'h100, 1, 0, 32'h100, 1, 32'h80, 0, 0);
      look(32'h100);
      // two not-taken resolutions, then lookup
      step(0, 32'h100, 1, 0, 32'h100, 0, 0, 1, 32'h80);
      step(0, 32'h100, 1, 0, 32'h100, 0, 0, 0, 0);
      look(32'h100);
      repeat (4) step(0, 32'h100, 1, 0, 32'h100, 1, 32'h80, 0, 0);
      look(32'h100);
      // JALR with alternating targets and a stale predicted target
      step(0, 32'h200, 0, 1, 32'h200, 0, 32'h300, 1, 32'h400);
      step(0, 32'h200, 0, 1, 32'h200, 0, 32'h400, 1, 32'h300);
      step(0, 32'h200, 0, 1, 32'h200, 0, 32'h300, 1, 32'h400);
      step(0, 32'h200, 0, 1, 32'h200, 0, 32'h300, 1, 32'h300);
      look(32'h200);
      // aliasing at index 0 between 0x100 and 0x140
      step(0, 32'h100, 1, 0, 32'h140, 0, 0, 0, 0);
      look(32'h100);
      step(0, 32'h140, 1, 0, 32'h140, 1, 32'h44, 0, 0);
      look(32'h100);
      look(32'h140);
      // reset during an update drops it and invalidates everything
      step(1, 32'h200, 1, 0, 32'h300, 1, 32'h500, 0, 0);
      look(32'h300);
      look(32'h200);
      look(32'h140);
      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         r   = ($urandom_range(0, 99) == 0);
         pcf = rnd_pc();
         pce = rnd_pc();
         br  = ($urandom_range(0, 2) != 0);
         jp  = !br && ($urandom_range(0, 3) == 0);
         src = $urandom_range(0, 1);
         act = 32'h1000 + ($urandom_range(0, 3) << 4);
         if ($urandom_range(0, 1) == 1) begin
            pte = m_hit(pce) && m_ctr[slot(pce)] >= 2;
            ptg = m_hit(pce) ? m_tgt[slot(pce)] : 32'h0;
         end else begin
            pte = $urandom_range(0, 1);
            ptg = 32'h1000 + ($urandom_range(0, 3) << 4);
         end
         step(r, pcf, br, jp, pce, src, act, pte, ptg);
      end
      // drain: the monitor must have consumed every expectation
      repeat (3) @(negedge clk);
      #1;
      chk("scoreboard_drain", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
